// File: rtl/serial_div_unit_pkg.sv
// Shared processor types used by the serial divider.
package ProcessorTypes;

  typedef enum logic [1:0] {
    DivUnitState_Idle = 2'd0,
    DivUnitState_Busy = 2'd1,
    DivUnitState_Done = 2'd2
  } DivUnitState;

  // Width of an iteration counter that must hold the value n.
  function automatic int div_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_div_unit_step.sv
// One radix-2 restoring division step: trial subtract and next partial remainder.
module serial_div_unit_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_in,
  input  logic         dvd_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] partial;
  logic [N:0] trial;

  // Shift the next dividend bit into the remainder and keep the difference only if it fits.
  always_comb begin
    partial = {rem_in, dvd_msb};
    trial   = partial - {1'b0, divisor};
    q_bit   = (partial >= {1'b0, divisor});
    rem_out = N'(q_bit ? trial : partial);
  end

endmodule

// File: rtl/serial_div_unit.sv
// Iterative restoring divider serving DIV/DIVU/REM/REMU over an enable/done handshake.
module serial_div_unit
  import ProcessorTypes::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remnant,
  input  logic         isSigned,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         enable,
  input  logic         stall,
  input  logic         flush
);

  localparam int CNT_W = div_cnt_width(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  DivUnitState state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvsr_q, dvsr_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [N-1:0]     quotient_q, quotient_d;
  logic [N-1:0]     remnant_q, remnant_d;

  logic             div_by_zero;
  logic             overflow;
  logic             last_step;
  logic [N-1:0]     step_rem;
  logic             step_q_bit;
  logic [N-1:0]     q_full;

  serial_div_unit_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[N-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Decode the special operand cases and the final iteration.
  always_comb begin
    div_by_zero = (divisor == '0);
    overflow    = isSigned && (dividend == MIN_NEG) && (divisor == ALL_ONES);
    last_step   = (cnt_q == CNT_W'(1));
    q_full      = {dvd_q[N-2:0], step_q_bit};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DivUnitState_Idle;
    else        state_q <= state_d;
  end

  // Next-state logic: flush beats stall, stall freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DivUnitState_Idle;
    end else if (!stall) begin
      unique case (state_q)
        DivUnitState_Idle: begin
          if (enable) state_d = (div_by_zero || overflow) ? DivUnitState_Done : DivUnitState_Busy;
        end
        DivUnitState_Busy: begin
          if (!enable)        state_d = DivUnitState_Idle;
          else if (last_step) state_d = DivUnitState_Done;
        end
        DivUnitState_Done: state_d = DivUnitState_Idle;
        default:           state_d = DivUnitState_Idle;
      endcase
    end
  end

  // Output decode: everything comes straight from registers.
  always_comb begin
    done     = (state_q == DivUnitState_Done);
    quotient = quotient_q;
    remnant  = remnant_q;
  end

  // Datapath next values: operand capture, shift/subtract iteration and sign fix.
  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvsr_d     = dvsr_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    quotient_d = quotient_q;
    remnant_d  = remnant_q;
    if (flush) begin
      cnt_d = '0;
    end else if (!stall) begin
      if (state_q == DivUnitState_Idle && enable) begin
        cnt_d   = CNT_W'(N);
        rem_d   = '0;
        dvd_d   = (isSigned && dividend[N-1]) ? -dividend : dividend;
        dvsr_d  = (isSigned && divisor[N-1]) ? -divisor : divisor;
        neg_q_d = isSigned && (dividend[N-1] ^ divisor[N-1]) && !div_by_zero;
        neg_r_d = isSigned && dividend[N-1];
        if (div_by_zero) begin
          quotient_d = ALL_ONES;
          remnant_d  = dividend;
        end else if (overflow) begin
          quotient_d = dividend;
          remnant_d  = '0;
        end
      end else if (state_q == DivUnitState_Busy && enable) begin
        rem_d = step_rem;
        dvd_d = q_full;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_step) begin
          quotient_d = neg_q_q ? -q_full : q_full;
          remnant_d  = neg_r_q ? -step_rem : step_rem;
        end
      end
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvsr_q     <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      quotient_q <= '0;
      remnant_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvsr_q     <= dvsr_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      quotient_q <= quotient_d;
      remnant_q  <= remnant_d;
    end
  end

endmodule

// File: doc/serial_div_unit.md
# serial_div_unit

Iterative radix-2 restoring divider that serves the integer DIV/DIVU/REM/REMU requests issued by the execute stage's mul/div wrapper. It is the responder side of the enable/done protocol: the execute stage holds `enable` with stable operands and stalls itself until `done`. The unit produces quotient and remainder together, with RISC-V M-extension semantics for divide-by-zero and signed overflow.

## Interface
- `N`, default 32: operand/result width (≥2).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `done` output 1: result valid this cycle.
- `quotient` output N: quotient result.
- `remnant` output N: remainder result.
- `isSigned` input 1: signed (DIV/REM) vs unsigned (DIVU/REMU); sampled at capture.
- `dividend` input N: dividend; sampled at capture.
- `divisor` input N: divisor; sampled at capture.
- `enable` input 1: request present; held high by initiator until `done`.
- `stall` input 1: pipeline stall; freezes all state.
- `flush` input 1: synchronous abort.

## Operation
- States: Idle, Busy, Done; `done` = (state == Done), decoded from the state register only.
- Priority per edge: reset > flush > stall > normal.
- Idle with `enable`: capture `isSigned`, |dividend|, |divisor|, negQ = signed & signs differ & divisor≠0, negR = signed & dividend negative. Load iteration counter with N.
  - divisor == 0: load quotient = all-ones, remnant = dividend, go to Done (fast path).
  - signed, dividend = 0x80…0, divisor = all-ones: load quotient = dividend, remnant = 0, go to Done (fast path).
  - Otherwise go to Busy.
- Busy, each non-stalled cycle: form trial = {rem[N-1:0], dvdShift[N-1]} − divisor in N+1 bits. If non-negative, rem ← trial and shift in q-bit 1; else shift in q-bit 0. Decrement the counter.
  - On the cycle the counter reaches 0, apply sign fix (two's-complement negate quotient if negQ, remainder if negR), register the results and go to Done.
  - If `enable` drops in Busy, return to Idle; result registers are unchanged.
- Done: `done`=1. If stall, stay in Done; else go to Idle. A new `enable` in the following Idle cycle starts a new operation, so back-to-back divides are supported.
- `flush` in any state: go to Idle next cycle and clear the counter. Result registers keep their values, and `done` is 0 in the next cycle.
- `quotient`/`remnant` are registered and hold their values until the next completion. Operand changes after capture are ignored.
- Reset values: state Idle, `done`=0, `quotient`=0, `remnant`=0, counter 0, internal shift registers 0.

## Timing
- Normal latency: `enable` first high in cycle 0 (Idle), `done`=1 in cycle N+1 (cycle 33 for N=32). This is extended by one cycle per stalled cycle.
- Fast-path latency: `done`=1 in cycle 1.
- `done` lasts exactly one non-stalled cycle. While stall is held in Done, `done` stays high.
- `rst_n` low at any time, including mid-Busy: all state clears immediately (asynchronously), and `done` deasserts in the same cycle.
- No combinational path from inputs to `done`/`quotient`/`remnant`.

## Structure
- Shared package (`ProcessorTypes`): `DivUnitState` enum {DivUnitState_Idle, DivUnitState_Busy, DivUnitState_Done}, plus the counter-width constant $clog2(N+1).
- One combinational sub-module, `serial_div_unit_step`: computes the trial subtraction and outputs the next rem/quotient bit. Everything else stays in one module.

## Test plan
- Unsigned: 100/7 → `done` at cycle 33, quotient 14, remnant 2. Then 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remnant 0.
- Signed: −7/2 → quotient 0xFFFFFFFD, remnant 0xFFFFFFFF. Then 7/−2 → quotient 0xFFFFFFFD, remnant 1.
- Fast paths: 5/0 (both modes) → cycle 1, quotient 0xFFFFFFFF, remnant 5. Signed 0x80000000/0xFFFFFFFF → cycle 1, quotient 0x80000000, remnant 0.
- Stall: 100/7 with stall high for 4 cycles mid-Busy → `done` at cycle 37. Stall in Done holds `done` and the results.
- Flush/abort: flush at cycle 10 of 100/7 → no `done`. Then 9/3 starting the next cycle → quotient 3, remnant 0 at its cycle 33.
- Reset: `rst_n` low at cycle 20 of a divide → `done`, `quotient`, `remnant` all 0 immediately. After release, a new 100/7 completes normally.
- Back-to-back: 100/7, then 50/6 asserted in the cycle after `done` → second result (8, 2) at its cycle 33.
